// File: rtl/signed_seq_multiplier.sv
// ---------------------------------------------------------------------------
// signed_seq_multiplier
//
// Sequential shift-and-add signed multiplier. Operands are captured on an
// accepted start, reduced to unsigned magnitudes, multiplied over WORD_LENGTH
// RUN iterations (one partial-product add per cycle), and then the result is
// negated when the externally supplied product sign is 1.
//
// The block sits downstream of a sign stage: it keeps that stage enabled while
// idle (sign_enable) and samples its `sign` output in the accepting cycle.
//
// Handshake: start is a level request sampled only in IDLE; the first IDLE
// cycle with start=1 accepts the job, and start is ignored in every other
// state. ready is a single-cycle pulse in DONE marking product as valid;
// product is then held until the next accepted job completes (or reset).
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset         synchronous, active-low reset
//   start         job request, accepted only in IDLE
//   multiplicand  signed two's-complement operand (WORD_LENGTH bits)
//   multiplier    signed two's-complement operand (WORD_LENGTH bits)
//   sign          product sign from the sign stage (1 = negative)
//   sign_enable   enable to the sign stage, 1 only in IDLE
//   busy          1 in RUN and SIGN
//   ready         one-cycle pulse in DONE, product valid
//   product       signed 2*WORD_LENGTH-bit result
//   state_dbg     current FSM state (IDLE=0, RUN=1, SIGN=2, DONE=3)
// ---------------------------------------------------------------------------
module signed_seq_multiplier #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    input  logic                       sign,
    output logic                       sign_enable,
    output logic                       busy,
    output logic                       ready,
    output logic [2*WORD_LENGTH-1:0]   product,
    output logic [1:0]                 state_dbg
);

    localparam int PW = 2 * WORD_LENGTH;
    localparam int CW = (WORD_LENGTH > 2) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [WORD_LENGTH-1:0] ONE_W    = 1;
    localparam logic [PW-1:0]          ONE_P    = 1;
    localparam logic [CW-1:0]          ONE_C    = 1;
    localparam logic [CW-1:0]          LAST_CNT = CW'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q,    state_d;
    logic [WORD_LENGTH-1:0] a_q,        a_d;        // |multiplicand|
    logic [WORD_LENGTH-1:0] b_q,        b_d;        // |multiplier|, shifts right
    logic                   sign_reg_q, sign_reg_d;
    logic [PW-1:0]          p_q,        p_d;        // unsigned accumulator
    logic [CW-1:0]          cnt_q,      cnt_d;      // iteration index
    logic [PW-1:0]          product_q,  product_d;

    // Two's-complement magnitude. The most negative value maps onto
    // 2^(WORD_LENGTH-1), which still fits because the result is unsigned.
    function automatic logic [WORD_LENGTH-1:0] magnitude(input logic [WORD_LENGTH-1:0] v);
        logic [WORD_LENGTH-1:0] m;
        if (v[WORD_LENGTH-1]) begin
            m = (~v) + ONE_W;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Partial product for this iteration: A weighted by the iteration index.
    logic [PW-1:0] addend;
    logic          last_iter;

    always_comb begin
        addend    = {{WORD_LENGTH{1'b0}}, a_q} << cnt_q;
        last_iter = (cnt_q == LAST_CNT);
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_reg_d = sign_reg_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        product_d  = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d        = magnitude(multiplicand);
                    b_d        = magnitude(multiplier);
                    sign_reg_d = sign;
                    p_d        = '0;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                end
            end

            S_RUN: begin
                if (b_q[0]) begin
                    p_d = p_q + addend;
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + ONE_C;
                // The add using index WORD_LENGTH-1 is the final one.
                if (last_iter) begin
                    state_d = S_SIGN;
                end
            end

            S_SIGN: begin
                // A zero magnitude negates to zero, so no special case needed.
                if (sign_reg_q) begin
                    product_d = (~p_q) + ONE_P;
                end else begin
                    product_d = p_q;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from the state register so they are glitch-free
    // and align with the state timeline.
    always_comb begin
        sign_enable = (state_q == S_IDLE);
        busy        = (state_q == S_RUN) || (state_q == S_SIGN);
        ready       = (state_q == S_DONE);
        product     = product_q;
        state_dbg   = state_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_reg_q <= 1'b0;
            p_q        <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_reg_q <= sign_reg_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
        end
    end

endmodule

// File: tb/tb_signed_seq_multiplier.sv
module tb_signed_seq_multiplier;

    localparam int W  = 16;
    localparam int PW = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          sign;
    logic          sign_enable;
    logic          busy;
    logic          ready;
    logic [PW-1:0] product;
    logic [1:0]    state_dbg;

    int n_vec;
    int n_err;

    signed_seq_multiplier #(.WORD_LENGTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .sign         (sign),
        .sign_enable  (sign_enable),
        .busy         (busy),
        .ready        (ready),
        .product      (product),
        .state_dbg    (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t tbl[6];

    // Reference: multiply the magnitudes, apply the supplied sign, keep 2W bits.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        longint ma, mb, m;
        ma = longint'(a);
        mb = longint'(b);
        if (a[W-1]) ma = 65536 - ma;
        if (b[W-1]) mb = 65536 - mb;
        m = ma * mb;
        if (s) m = -m;
        return m[PW-1:0];
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits for IDLE, issues one job and follows it to ready (bounded).
    // Returns at the negedge where ready is high.
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output logic [PW-1:0] prod, output int lat, output int bcnt);
        int guard;
        guard = 0;
        while (!sign_enable && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        multiplicand = a;
        multiplier   = b;
        sign         = s;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = busy ? 1 : 0;
        while (!ready && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        prod = product;
    endtask

    initial begin
        logic [PW-1:0] prod;
        logic [PW-1:0] held;
        logic [W-1:0]  ra, rb;
        logic          rs;
        int lat, bcnt, rdy_cnt, guard;

        n_vec = 0;
        n_err = 0;

        tbl[0] = '{a: 16'd3,    b: 16'd5,    s: 1'b0, exp: 32'h0000000F};
        tbl[1] = '{a: 16'hFFFD, b: 16'd5,    s: 1'b1, exp: 32'hFFFFFFF1};
        tbl[2] = '{a: 16'h8000, b: 16'h8000, s: 1'b0, exp: 32'h40000000};
        tbl[3] = '{a: 16'h8000, b: 16'h7FFF, s: 1'b1, exp: 32'hC0008000};
        tbl[4] = '{a: 16'd0,    b: 16'hFFF9, s: 1'b1, exp: 32'h00000000};
        tbl[5] = '{a: 16'd3,    b: 16'd5,    s: 1'b1, exp: 32'hFFFFFFF1};

        // Reset
        reset        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        sign         = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_product", product, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_sign_enable", {31'd0, sign_enable}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i].a, tbl[i].b, tbl[i].s, prod, lat, bcnt);
            check($sformatf("tbl%0d_product", i), prod, tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd18);
            check($sformatf("tbl%0d_busy_cycles", i), 32'(bcnt), 32'd17);
            if (i == 1) begin
                // Product must hold in IDLE after the ready pulse.
                held = prod;
                repeat (4) begin
                    @(negedge clk);
                    check("hold_ready_low", {31'd0, ready}, 32'd0);
                    check("hold_product", product, held);
                end
            end
        end

        // Randomized jobs against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 65535));
            rb = W'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) ra = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
            if ($urandom_range(0, 3) == 0) rb = (i % 3 == 0) ? 16'h0000 : 16'hFFFF;
            rs = ra[W-1] ^ rb[W-1];
            if ($urandom_range(0, 3) == 0) rs = 1'($urandom_range(0, 1));
            run_job(ra, rb, rs, prod, lat, bcnt);
            check($sformatf("rand%0d_%04h_%04h_%0d", i, ra, rb, rs), prod, ref_mul(ra, rb, rs));
        end

        // Start pulsed mid-RUN is ignored; exactly one ready
        @(negedge clk);
        multiplicand = 16'd3;
        multiplier   = 16'd5;
        sign         = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        multiplicand = 16'd9;
        multiplier   = 16'd9;
        start        = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        rdy_cnt = 0;
        held    = '0;
        for (int k = 0; k < 30; k++) begin
            if (ready) begin
                rdy_cnt++;
                held = product;
            end
            @(negedge clk);
        end
        check("midrun_ready_count", 32'(rdy_cnt), 32'd1);
        check("midrun_product", held, 32'h0000000F);
        check("midrun_product_after", product, 32'h0000000F);

        // Start held high across DONE: accepted on the following IDLE cycle
        multiplicand = 16'd2;
        multiplier   = 16'd3;
        sign         = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        multiplicand = 16'd4;
        multiplier   = 16'hFFFB;
        sign         = 1'b1;
        start        = 1'b1;
        guard        = 0;
        while (!ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("held_first_ready", {31'd0, ready}, 32'd1);
        check("held_first_product", product, 32'h00000006);
        @(negedge clk);
        check("held_idle_sign_enable", {31'd0, sign_enable}, 32'd1);
        check("held_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("held_accept_busy", {31'd0, busy}, 32'd1);
        check("held_accept_sign_enable", {31'd0, sign_enable}, 32'd0);
        start = 1'b0;
        lat   = 1;
        while (!ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("held_second_latency", 32'(lat), 32'd18);
        check("held_second_product", product, 32'hFFFFFFEC);

        // Reset in the middle of RUN discards the job
        @(negedge clk);
        multiplicand = 16'h1234;
        multiplier   = 16'h0F0F;
        sign         = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_product", product, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_ready", {31'd0, ready}, 32'd0);
        check("midreset_sign_enable", {31'd0, sign_enable}, 32'd1);
        reset   = 1'b1;
        rdy_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (ready) rdy_cnt++;
        end
        check("midreset_no_ready", 32'(rdy_cnt), 32'd0);
        run_job(16'd7, 16'hFFFA, 1'b1, prod, lat, bcnt);
        check("post_reset_product", prod, 32'hFFFFFFD6);
        check("post_reset_latency", 32'(lat), 32'd18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
